prog_clk_div: RTL and testbench



---
 rtl/prog_clk_div.sv | 121 ++++++++++++
 tb/tb_prog_clk_div.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock/strobe divider with double-buffered config and global sync.
// Optional macro PROG_CLK_DIV_PHASE_EN adds a per-channel start phase (cfg_phase).
module prog_clk_div #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int DEF_PERIOD = 60000,
    parameter int DEF_HIGH   = 30000,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
`ifdef PROG_CLK_DIV_PHASE_EN
    input  logic [CNT_W-1:0]  cfg_phase,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    logic             cfg_ok;
    logic [CNT_W-1:0] cfg_per_clamped;

    assign cfg_ok          = cfg_we && (32'(cfg_ch) < 32'(NUM_CH));
    // Periods below 2 cannot produce a wrap distinct from cnt=0.
    assign cfg_per_clamped = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] per_q, per_d, high_q, high_d;
        logic [CNT_W-1:0] sh_per_q, sh_per_d, sh_high_q, sh_high_d;
        logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
        logic [CNT_W-1:0] cnt_cur, sync_load;
        logic             en, hit, last, apply;
`ifdef PROG_CLK_DIV_PHASE_EN
        logic [CNT_W-1:0] phase_q, phase_d;
        logic             en_prev_q, en_prev_d;
`endif

        always_comb begin
            en  = ch_en[i];
            hit = cfg_ok && (cfg_ch == CH_W'(i));
`ifdef PROG_CLK_DIV_PHASE_EN
            // A fresh enable behaves as if the counter were sitting at the phase offset.
            cnt_cur   = cnt_q;
            if (en && !en_prev_q)
                cnt_cur = (phase_q >= per_q) ? '0 : phase_q;
            phase_d   = hit ? cfg_phase : phase_q;
            en_prev_d = en;
`else
            cnt_cur   = cnt_q;
`endif
            last   = (cnt_cur == per_q - CNT_W'(1));
            clk_d  = en && (cnt_cur < high_q);
            tick_d = en && last && !sync;
            apply  = pend_q && (sync || !en || last);

            per_d     = apply ? sh_per_q  : per_q;
            high_d    = apply ? sh_high_q : high_q;
            pend_d    = apply ? 1'b0 : pend_q;
            sh_per_d  = sh_per_q;
            sh_high_d = sh_high_q;
            // Write lands after apply so a same-cycle write stays pending.
            if (hit) begin
                sh_per_d  = cfg_per_clamped;
                sh_high_d = cfg_high;
                pend_d    = 1'b1;
            end

`ifdef PROG_CLK_DIV_PHASE_EN
            sync_load = (phase_q >= per_d) ? '0 : phase_q;
`else
            sync_load = '0;
`endif
            if (!en)       cnt_d = '0;
            else if (sync) cnt_d = sync_load;
            else if (last) cnt_d = '0;
            else           cnt_d = cnt_cur + CNT_W'(1);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q     <= '0;
                per_q     <= CNT_W'(DEF_PERIOD);
                high_q    <= CNT_W'(DEF_HIGH);
                sh_per_q  <= CNT_W'(DEF_PERIOD);
                sh_high_q <= CNT_W'(DEF_HIGH);
                pend_q    <= 1'b0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
`ifdef PROG_CLK_DIV_PHASE_EN
                phase_q   <= '0;
                en_prev_q <= 1'b0;
`endif
            end else begin
                cnt_q     <= cnt_d;
                per_q     <= per_d;
                high_q    <= high_d;
                sh_per_q  <= sh_per_d;
                sh_high_q <= sh_high_d;
                pend_q    <= pend_d;
                clk_q     <= clk_d;
                tick_q    <= tick_d;
`ifdef PROG_CLK_DIV_PHASE_EN
                phase_q   <= phase_d;
                en_prev_q <= en_prev_d;
`endif
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Randomized bench for prog_clk_div against a period-position reference model, plus directed literal checks.
module tb_prog_clk_div;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
    localparam int DEF_P  = 10;
    localparam int DEF_H  = 5;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_period = '0;
    logic [CNT_W-1:0]  cfg_high = '0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              sync = 1'b0;
    logic [NUM_CH-1:0] clk_out, tick, pend;

    prog_clk_div #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_P), .DEF_HIGH(DEF_H)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high), .ch_en(ch_en), .sync(sync),
        .clk_out(clk_out), .tick(tick), .pend(pend)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current period plus active/shadow settings.
    int pos [NUM_CH];
    int per [NUM_CH];
    int hi  [NUM_CH];
    int sper[NUM_CH];
    int shi [NUM_CH];
    logic [NUM_CH-1:0] e_clk = '0, e_tick = '0, e_pend = '0;
    bit mdl_ok = 1'b0;
    int hi_cnt[NUM_CH];
    int tk_cnt[NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit en, last, apply;
        for (int c = 0; c < NUM_CH; c++) begin
            en = ch_en[c];
            if (reset) begin
                pos[c] = 0; per[c] = DEF_P; hi[c] = DEF_H; sper[c] = DEF_P; shi[c] = DEF_H;
                e_clk[c] = 1'b0; e_tick[c] = 1'b0; e_pend[c] = 1'b0;
            end else begin
                e_clk[c]  = en && (pos[c] < hi[c]);
                last      = en && (pos[c] == per[c] - 1);
                e_tick[c] = last && !sync;
                apply     = e_pend[c] && (sync || !en || last);
                pos[c]    = (!en || sync) ? 0 : (pos[c] + 1) % per[c];
                if (apply) begin
                    per[c] = sper[c]; hi[c] = shi[c]; e_pend[c] = 1'b0;
                end
                if (cfg_we && int'(cfg_ch) == c) begin
                    sper[c]   = (cfg_period < 2) ? 2 : int'(cfg_period);
                    shi[c]    = int'(cfg_high);
                    e_pend[c] = 1'b1;
                end
            end
        end
        mdl_ok = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mdl_ok) begin
            check("clk_out", 32'(clk_out), 32'(e_clk));
            check("tick",    32'(tick),    32'(e_tick));
            check("pend",    32'(pend),    32'(e_pend));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                hi_cnt[c] += int'(clk_out[c]);
                tk_cnt[c] += int'(tick[c]);
            end
        end
    endtask

    task automatic clr();
        for (int c = 0; c < NUM_CH; c++) begin
            hi_cnt[c] = 0; tk_cnt[c] = 0;
        end
    endtask

    task automatic wr(input int ch, input int p, input int h);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_period = CNT_W'(p); cfg_high = CNT_W'(h);
        step(1);
        cfg_we = 1'b0;
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_pend",    32'(pend),    0);

        ch_en = '1; clr(); step(20);
        check("def_hi0", hi_cnt[0], 10);
        check("def_tk0", tk_cnt[0], 2);

        step(3);
        wr(0, 6, 2);
        check("mid_pend0_set", 32'(pend[0]), 1);
        step(6);
        check("mid_pend0_clr", 32'(pend[0]), 0);
        clr(); step(12);
        check("new_hi0", hi_cnt[0], 4);
        check("new_tk0", tk_cnt[0], 2);
        check("ch1_hi",  hi_cnt[1], 7);

        wr(0, 4, 0);
        wr(1, 1, 1);
        wr(2, 10, 12);
        step(25);
        clr(); step(8);
        check("high0_hi", hi_cnt[0], 0);
        check("high0_tk", tk_cnt[0], 2);
        check("per1_hi",  hi_cnt[1], 4);
        check("hi_ge_per", hi_cnt[2], 8);

        wr(0, 10, 5);
        wr(1, 10, 5);
        step(17);
        sync = 1'b1; step(1); sync = 1'b0;
        check("sync_tick", 32'(tick), 0);
        step(1);
        check("sync_align", 32'(clk_out[1:0]), 3);

        step(2);
        ch_en = 3'b101; step(1);
        check("dis_clk1", 32'(clk_out[1]), 0);
        wr(1, 8, 3);
        check("dis_pend1_set", 32'(pend[1]), 1);
        step(1);
        check("dis_pend1_clr", 32'(pend[1]), 0);
        ch_en = 3'b111; clr(); step(8);
        check("reen_hi1", hi_cnt[1], 3);
        check("reen_tk1", tk_cnt[1], 1);

        wr(0, 5, 1);
        reset = 1'b1; step(1); reset = 1'b0;
        check("rst_mid_pend", 32'(pend), 0);
        check("rst_mid_clk",  32'(clk_out), 0);
        clr(); step(20);
        check("rst_mid_hi0", hi_cnt[0], 10);

        repeat (3000) begin
            cfg_we     = ($urandom_range(7) == 0);
            cfg_ch     = CH_W'($urandom_range(3));
            cfg_period = CNT_W'($urandom_range(15));
            cfg_high   = CNT_W'($urandom_range(18));
            sync       = ($urandom_range(39) == 0);
            reset      = ($urandom_range(499) == 0);
            if ($urandom_range(15) == 0) ch_en = NUM_CH'($urandom);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
